// File: rtl/gpio_input_port_if.sv
// CPU data-memory port bundle for the GPIO input peripheral (word offset, write data, read data).
interface gpio_input_port_if;
  logic        SEL;
  logic [1:0]  RAM_ADDR;
  logic [31:0] RAM_WRITE_DATA;
  logic        RAM_WRITE_ENABLE;
  logic [31:0] RAM_READ_DATA;

  modport master (
    output SEL,
    output RAM_ADDR,
    output RAM_WRITE_DATA,
    output RAM_WRITE_ENABLE,
    input  RAM_READ_DATA
  );

  modport slave (
    input  SEL,
    input  RAM_ADDR,
    input  RAM_WRITE_DATA,
    input  RAM_WRITE_ENABLE,
    output RAM_READ_DATA
  );
endinterface

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: synchronise, optionally debounce (GPIO_IN_DEBOUNCE_EN), latch
// rising/falling edges as W1C pending flags and raise a maskable IRQ. Registered 1-cycle reads.
module gpio_input_port #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   GPIO_IN,
  gpio_input_port_if.slave   bus,
  output logic               IRQ
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_rise_pend;
  logic [WIDTH-1:0] r_fall_pend;
  logic [WIDTH-1:0] r_irq_mask;
  logic [31:0]      r_rdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable_d;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rise_clr;
  logic [WIDTH-1:0] w_fall_clr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_rdata_sel;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_wdata = bus.RAM_WRITE_DATA[WIDTH-1:0];
  assign w_wr    = bus.SEL & bus.RAM_WRITE_ENABLE;
  assign w_rd    = bus.SEL & ~bus.RAM_WRITE_ENABLE;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] r_cnt   [WIDTH];
  logic [CntW-1:0] w_cnt_d [WIDTH];

  // A changed value is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles.
  always_comb begin
    w_stable_d = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_d[i] = '0;
      if (w_sync[i] != r_stable[i]) begin
        if (r_cnt[i] == CntLast) begin
          w_stable_d[i] = w_sync[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '{default: '0};
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  always_comb begin
    w_stable_d = w_sync;
  end
`endif

  always_comb begin
    w_rise     = w_stable_d & ~r_stable;
    w_fall     = ~w_stable_d & r_stable;
    w_rise_clr = '0;
    w_fall_clr = '0;
    if (w_wr && bus.RAM_ADDR == 2'd1) w_rise_clr = w_wdata;
    if (w_wr && bus.RAM_ADDR == 2'd2) w_fall_clr = w_wdata;
  end

  always_comb begin
    w_rdata_sel = '0;
    unique case (bus.RAM_ADDR)
      2'd0: w_rdata_sel[WIDTH-1:0] = r_stable;
      2'd1: w_rdata_sel[WIDTH-1:0] = r_rise_pend;
      2'd2: w_rdata_sel[WIDTH-1:0] = r_fall_pend;
      2'd3: w_rdata_sel[WIDTH-1:0] = r_irq_mask;
      default: w_rdata_sel = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync      <= '{default: '0};
      r_stable    <= '0;
      r_rise_pend <= '0;
      r_fall_pend <= '0;
      r_irq_mask  <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_sync[0] <= GPIO_IN;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_stable <= w_stable_d;
      // A new edge in the same cycle as a W1C clear keeps the flag set.
      r_rise_pend <= (r_rise_pend & ~w_rise_clr) | w_rise;
      r_fall_pend <= (r_fall_pend & ~w_fall_clr) | w_fall;
      if (w_wr && bus.RAM_ADDR == 2'd3) begin
        r_irq_mask <= w_wdata;
      end
      r_rdata <= w_rd ? w_rdata_sel : 32'h0;
      r_irq   <= |((r_rise_pend | r_fall_pend) & r_irq_mask);
    end
  end

  assign bus.RAM_READ_DATA = r_rdata;
  assign IRQ               = r_irq;

endmodule

// File: tb/tb_gpio_input_port.sv
// Directed self-checking bench for gpio_input_port; follows GPIO_IN_DEBOUNCE_EN like the RTL.
module tb_gpio_input_port;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int Lat = 6;
`else
  localparam int Lat = 3;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic        irq;
  int          n_vec;
  int          n_err;

  gpio_input_port_if bus_if ();

  gpio_input_port #(
    .WIDTH          (32),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .GPIO_IN(gpio_in),
    .bus    (bus_if),
    .IRQ    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus_if.SEL              = 1'b1;
    bus_if.RAM_WRITE_ENABLE = 1'b1;
    bus_if.RAM_ADDR         = addr;
    bus_if.RAM_WRITE_DATA   = data;
    tick();
    bus_if.SEL              = 1'b0;
    bus_if.RAM_WRITE_ENABLE = 1'b0;
    check("wr_rdata_zero", bus_if.RAM_READ_DATA, 32'h0);
  endtask

  task automatic rd_check(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus_if.SEL              = 1'b1;
    bus_if.RAM_WRITE_ENABLE = 1'b0;
    bus_if.RAM_ADDR         = addr;
    tick();
    bus_if.SEL = 1'b0;
    check(tag, bus_if.RAM_READ_DATA, exp);
  endtask

  initial begin
    n_vec                   = 0;
    n_err                   = 0;
    rst                     = 1'b1;
    gpio_in                 = 32'hFFFF_FFFF;
    bus_if.SEL              = 1'b1;
    bus_if.RAM_ADDR         = 2'd0;
    bus_if.RAM_WRITE_DATA   = 32'h0;
    bus_if.RAM_WRITE_ENABLE = 1'b0;

    // Reset with a selected read pending: outputs must stay quiet.
    tick();
    check("rst_rdata_1", bus_if.RAM_READ_DATA, 32'h0);
    check("rst_irq_1", {31'h0, irq}, 32'h0);
    tick();
    check("rst_rdata_2", bus_if.RAM_READ_DATA, 32'h0);
    check("rst_irq_2", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // Continuous DATA reads pin down the exact edge at which stable changes.
    for (int j = 1; j <= Lat + 1; j++) begin
      tick();
      if (j == Lat)     check("rst_data_pre", bus_if.RAM_READ_DATA, 32'h0);
      if (j == Lat + 1) check("rst_data_post", bus_if.RAM_READ_DATA, 32'hFFFF_FFFF);
    end
    bus_if.SEL = 1'b0;
    rd_check(2'd1, 32'hFFFF_FFFF, "rst_rise_pend");
    rd_check(2'd2, 32'h0, "rst_fall_pend");
    wr(2'd1, 32'hFFFF_FFFF);
    rd_check(2'd1, 32'h0, "rise_w1c");
    check("irq_unmasked", {31'h0, irq}, 32'h0);

    // Read latency and idle zero.
    gpio_in = 32'h0000_00A5;
    repeat (12) tick();
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd_check(2'd0, 32'h0000_00A5, "data_a5");
    tick();
    check("idle_zero", bus_if.RAM_READ_DATA, 32'h0);

    wr(2'd3, 32'h1234_5678);
    rd_check(2'd3, 32'h1234_5678, "mask_rw");
    wr(2'd3, 32'h0000_0001);
    repeat (2) tick();
    check("irq_quiet", {31'h0, irq}, 32'h0);

    // Pin 0 falls with mask bit 0 set: IRQ one edge after FALL_PEND.
    gpio_in = 32'h0000_00A4;
    for (int j = 1; j <= Lat + 1; j++) begin
      tick();
      if (j == Lat)     check("irq_pre", {31'h0, irq}, 32'h0);
      if (j == Lat + 1) check("irq_set", {31'h0, irq}, 32'h1);
    end
    rd_check(2'd2, 32'h0000_0001, "fall_pend0");
    wr(2'd2, 32'h0000_0001);
    check("irq_hold", {31'h0, irq}, 32'h1);
    tick();
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd_check(2'd2, 32'h0, "fall_cleared");

    // Pin 7 falls but is masked off.
    gpio_in = 32'h0000_0024;
    repeat (Lat + 3) tick();
    check("irq_masked", {31'h0, irq}, 32'h0);
    rd_check(2'd2, 32'h0000_0080, "fall_pend7");
    wr(2'd2, 32'h0000_0080);

    // W1C of bit 4 lands on the same edge pin 4's rise is latched.
    gpio_in = 32'h0000_0034;
    repeat (Lat - 1) tick();
    wr(2'd1, 32'h0000_0010);
    rd_check(2'd1, 32'h0000_0010, "collide_keep");
    wr(2'd1, 32'h0000_0010);
    rd_check(2'd1, 32'h0, "rise_clr4");

    wr(2'd0, 32'h0);
    rd_check(2'd0, 32'h0000_0034, "data_ro");

    gpio_in = 32'h0;
    repeat (12) tick();
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);

`ifdef GPIO_IN_DEBOUNCE_EN
    // 3-cycle glitch is rejected; a held level is accepted at edge k+6.
    gpio_in = 32'h0000_0008;
    repeat (3) tick();
    gpio_in = 32'h0;
    repeat (10) tick();
    rd_check(2'd0, 32'h0, "glitch_data");
    rd_check(2'd1, 32'h0, "glitch_rise");
    gpio_in                 = 32'h0000_0008;
    bus_if.SEL              = 1'b1;
    bus_if.RAM_WRITE_ENABLE = 1'b0;
    bus_if.RAM_ADDR         = 2'd0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 6) check("deb_pre", bus_if.RAM_READ_DATA, 32'h0);
      if (j == 7) check("deb_post", bus_if.RAM_READ_DATA, 32'h0000_0008);
    end
    bus_if.SEL = 1'b0;
    rd_check(2'd1, 32'h0000_0008, "deb_rise");
`else
    // Single-cycle pulse passes straight through and sets both flags.
    gpio_in                 = 32'h0000_0080;
    bus_if.SEL              = 1'b1;
    bus_if.RAM_WRITE_ENABLE = 1'b0;
    bus_if.RAM_ADDR         = 2'd0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 1) gpio_in = 32'h0;
      if (j == 3) check("pulse_pre", bus_if.RAM_READ_DATA, 32'h0);
      if (j == 4) check("pulse_high", bus_if.RAM_READ_DATA, 32'h0000_0080);
      if (j == 5) check("pulse_post", bus_if.RAM_READ_DATA, 32'h0);
    end
    bus_if.SEL = 1'b0;
    rd_check(2'd1, 32'h0000_0080, "pulse_rise");
    rd_check(2'd2, 32'h0000_0080, "pulse_fall");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_input_port.md
Name: gpio_input_port

Overview:
- Memory-mapped GPIO *input* peripheral: the read-side counterpart of the CPU's 32-bit GPIO output.
- Sits on the CPU data-memory port (10-bit word address, 32-bit data, WRITE_ENABLE) beside the SRAM; the top-level decode drives SEL.
- Synchronises and debounces 32 external pins, latches rising/falling edges as pending flags and raises a maskable IRQ.
- Read timing matches the SRAM: registered, 1-cycle latency.

Parameters:
- WIDTH, 32, number of input pins (1..32); unused upper register bits read 0.
- SYNC_STAGES, 2, synchroniser flop stages (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a changed synchronised value must persist before acceptance (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- GPIO_IN  input  WIDTH  asynchronous external pins.
- SEL  input  1  block selected this cycle (top-level address decode).
- RAM_ADDR  input  2  word offset within the block (CPU address bits [1:0]).
- RAM_WRITE_DATA  input  32  write data.
- RAM_WRITE_ENABLE  input  1  1 = write, 0 = read (qualified by SEL).
- RAM_READ_DATA  output  32  registered read data; 0 when the previous cycle was not a selected read.
- IRQ  output  1  registered interrupt request.

Behaviour:
- Register map:
  - 0 DATA (RO): debounced pin state.
  - 1 RISE_PEND (W1C).
  - 2 FALL_PEND (W1C).
  - 3 IRQ_MASK (RW).
- Reset (RST=1 at an edge):
  - Synchronisers, stable state, debounce counters, RISE_PEND, FALL_PEND and IRQ_MASK <= 0.
  - RAM_READ_DATA <= 0; IRQ <= 0.
  - Reset mid-debounce discards the partial count. The reset deasserting edge generates no edge flags.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; its output is `sync`.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
  - Latency from a pin change sampled at edge k: stable changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES (defaults: k+6).
- Edge detect:
  - The cycle stable goes 0->1 sets RISE_PEND[i].
  - The cycle stable goes 1->0 sets FALL_PEND[i].
  - Flags are sticky until cleared.
- Writes (SEL=1, RAM_WRITE_ENABLE=1):
  - Offset 1/2: each bit written 1 clears that pending bit. A set event for the same bit in the same cycle wins (flag stays 1).
  - Offset 3: IRQ_MASK <= RAM_WRITE_DATA[WIDTH-1:0].
  - Offset 0: ignored.
  - RAM_READ_DATA <= 0 on write cycles.
- Reads (SEL=1, RAM_WRITE_ENABLE=0):
  - RAM_READ_DATA <= selected register, zero-extended, at the same edge; the CPU sees it the following cycle.
  - Read value is the pre-update value. A read does not clear anything.
- Idle (SEL=0): RAM_READ_DATA <= 0, so the top can OR it with the SRAM output.
- IRQ <= |((RISE_PEND | FALL_PEND) & IRQ_MASK), computed from the register values updated at the same edge (one cycle after the flag sets).
- Back-to-back accesses are supported every cycle with no wait states.

Optional Feature:
- Macro: GPIO_IN_DEBOUNCE_EN.
- Defined: debounce counters exist as described; DATA latency is SYNC_STAGES+DEBOUNCE_CYCLES.
- Undefined: no counters, stable <= sync every cycle; latency is SYNC_STAGES+1 (defaults: 3); single-cycle glitches produce edge flags; DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset sequence: hold RST 2 cycles with GPIO_IN=32'hFFFF_FFFF, then release -> RAM_READ_DATA=0 and IRQ=0 during reset; DATA reads 32'hFFFF_FFFF 6 cycles after release (macro defined); RISE_PEND=32'hFFFF_FFFF (0->1 transition after reset).
- Debounce: GPIO_IN[3] pulsed high 3 cycles -> DATA[3] stays 0, RISE_PEND=0; held 4+ cycles -> DATA=32'h8 at edge k+6, RISE_PEND=32'h8.
- Read latency: SEL=1, RAM_ADDR=0, WE=0 at edge n with DATA=32'h0000_00A5 -> RAM_READ_DATA=32'hA5 after edge n, and 0 after edge n+1 with SEL=0.
- IRQ/mask: IRQ_MASK=32'h1, pin 0 falls -> FALL_PEND=32'h1, IRQ=1 one cycle later; write 32'h1 to offset 2 -> FALL_PEND=0, IRQ=0 next cycle.
- Set/clear collision: W1C write 32'h10 to offset 1 on the same edge that pin 4 rises -> RISE_PEND[4] remains 1.
- Macro undefined: a 1-cycle pulse on pin 7 -> DATA[7] high for exactly 1 cycle; RISE_PEND and FALL_PEND bit 7 both set; latency 3 cycles.
